pattern_history_table: RTL and testbench

PATTERN_HISTORY_TABLE -- requirements
Module: pattern_history_table

---
 rtl/pattern_history_table_pkg.sv | 19 +
 rtl/pattern_history_table_counter.sv | 19 +
 rtl/pattern_history_table.sv | 79 +++++++
 tb/tb_pattern_history_table.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pattern_history_table_pkg.sv
// Shared types and helpers for the pattern history table: counter encoding,
// reset value and PC-to-index extraction.
package pattern_history_table_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_state_t;

  localparam ctr_state_t CTR_RESET = WEAK_NT;

  // Word-aligned PCs: drop the byte offset; callers keep the low IDX_BITS.
  function automatic logic [29:0] pc_index(input logic [31:0] pc);
    return pc[31:2];
  endfunction

endpackage

// File: rtl/pattern_history_table_counter.sv
// branch_counter: next-state logic of a 2-bit saturating direction counter.
module branch_counter
  import pattern_history_table_pkg::*;
(
  input  logic       result,
  input  ctr_state_t state,
  output ctr_state_t counter
);

  always_comb begin
    counter = state;
    if (result) begin
      if (state != STRONG_T) counter = ctr_state_t'(state + 2'd1);
    end else begin
      if (state != STRONG_NT) counter = ctr_state_t'(state - 2'd1);
    end
  end

endmodule

// File: rtl/pattern_history_table.sv
// Pattern history table of 2-bit saturating counters, bimodal by default;
// define GSHARE_EN to XOR a global history register into both indices.
module pattern_history_table
  import pattern_history_table_pkg::*;
#(
  parameter int IDX_BITS = 5,
  parameter int GHR_BITS = IDX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pred_pc,
  output logic                pred_taken,
  output logic [1:0]          pred_state,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                update_valid,
  input  logic [31:0]         update_pc,
  input  logic                update_taken,
  input  logic [GHR_BITS-1:0] update_ghr
);

  localparam int ENTRIES = 1 << IDX_BITS;

  ctr_state_t          table_q [ENTRIES];
  ctr_state_t          write_data;
  logic [29:0]         pred_base;
  logic [29:0]         update_base;
  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] update_idx;
  logic                unused_bits;

  assign pred_base   = pc_index(pred_pc);
  assign update_base = pc_index(update_pc);

`ifdef GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (update_valid) begin
      ghr_q <= {ghr_q[GHR_BITS-2:0], update_taken};
    end
  end

  assign pred_idx    = pred_base[IDX_BITS-1:0] ^ ghr_q[IDX_BITS-1:0];
  assign update_idx  = update_base[IDX_BITS-1:0] ^ update_ghr[IDX_BITS-1:0];
  assign pred_ghr    = ghr_q;
  assign unused_bits = ^{pred_base[29:IDX_BITS], update_base[29:IDX_BITS],
                         pred_pc[1:0], update_pc[1:0]};
`else
  assign pred_idx    = pred_base[IDX_BITS-1:0];
  assign update_idx  = update_base[IDX_BITS-1:0];
  assign pred_ghr    = '0;
  assign unused_bits = ^{pred_base[29:IDX_BITS], update_base[29:IDX_BITS],
                         pred_pc[1:0], update_pc[1:0], update_ghr};
`endif

  // Read is straight from the registered array: a same-cycle update is not
  // bypassed, so the new value shows one cycle later.
  assign pred_state = table_q[pred_idx];
  assign pred_taken = pred_state[1];

  branch_counter u_counter (
    .result  (update_taken),
    .state   (table_q[update_idx]),
    .counter (write_data)
  );

  // update_valid is a one-cycle valid with no ready: the table always accepts
  // it, and update_pc/update_taken are don't-care while it is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= CTR_RESET;
    end else if (update_valid) begin
      table_q[update_idx] <= write_data;
    end
  end

endmodule

// File: tb/tb_pattern_history_table.sv
// Directed bench for pattern_history_table; the GSHARE_EN build runs the
// history-indexing sequence instead of the bimodal one.
module tb_pattern_history_table;

  localparam int IDX_BITS = 5;
  localparam int GHR_BITS = 5;

  logic                clk;
  logic                rst;
  logic [31:0]         pred_pc;
  logic                pred_taken;
  logic [1:0]          pred_state;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                update_valid;
  logic [31:0]         update_pc;
  logic                update_taken;
  logic [GHR_BITS-1:0] update_ghr;

  int checks_total;
  int checks_passed;

  pattern_history_table #(.IDX_BITS(IDX_BITS), .GHR_BITS(GHR_BITS)) dut (
    .clk          (clk),
    .rst          (rst),
    .pred_pc      (pred_pc),
    .pred_taken   (pred_taken),
    .pred_state   (pred_state),
    .pred_ghr     (pred_ghr),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .update_ghr   (update_ghr)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) begin
      checks_passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pred(input string tag, input logic [31:0] pc,
                            input logic [1:0] exp_state);
    pred_pc = pc;
    #1;
    check({tag, "_state"}, {30'd0, pred_state}, {30'd0, exp_state});
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_state[1]});
  endtask

  task automatic do_update(input logic [31:0] pc, input logic taken,
                           input logic [GHR_BITS-1:0] ghr);
    update_valid = 1'b1;
    update_pc    = pc;
    update_taken = taken;
    update_ghr   = ghr;
    step();
    update_valid = 1'b0;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst           = 1'b1;
    pred_pc       = 32'h60;
    update_valid  = 1'b0;
    update_pc     = 32'h0;
    update_taken  = 1'b0;
    update_ghr    = '0;
    step();
    check_pred("in_reset", 32'h60, 2'b01);
    check("in_reset_ghr", {27'd0, pred_ghr}, 32'd0);
    step();
    rst = 1'b0;
    check_pred("after_reset", 32'h60, 2'b01);
    check("after_reset_ghr", {27'd0, pred_ghr}, 32'd0);

`ifdef GSHARE_EN
    do_update(32'h100, 1'b1, 5'd0);
    do_update(32'h100, 1'b1, 5'd0);
    do_update(32'h100, 1'b0, 5'd0);
    check("ghr_shift", {27'd0, pred_ghr}, 32'h06);
    // entry 30 still at reset value; entry 0 went 01->10->11->10
    check_pred("gs_entry30", 32'h60, 2'b01);
    check_pred("gs_entry0", 32'h18, 2'b10);
    // update index 24^6 = 30; history becomes 01101
    do_update(32'h60, 1'b1, 5'd6);
    check("ghr_after4", {27'd0, pred_ghr}, 32'h0D);
    check_pred("gs_entry30_trained", 32'h4C, 2'b10);
    check_pred("gs_entry24_via_ghr", 32'h60, 2'b01);
`else
    do_update(32'h60, 1'b1, '0);
    check_pred("inc1", 32'h60, 2'b10);
    do_update(32'h60, 1'b1, '0);
    check_pred("inc2", 32'h60, 2'b11);
    do_update(32'h60, 1'b1, '0);
    check_pred("sat_hi", 32'h60, 2'b11);
    do_update(32'h60, 1'b0, '0);
    check_pred("dec1", 32'h60, 2'b10);
    do_update(32'h60, 1'b0, '0);
    check_pred("dec2", 32'h60, 2'b01);
    do_update(32'h60, 1'b0, '0);
    check_pred("dec3", 32'h60, 2'b00);
    do_update(32'h60, 1'b0, '0);
    check_pred("sat_lo", 32'h60, 2'b00);
    check_pred("alias_e0", 32'hE0, 2'b00);
    check_pred("alias_lowbits", 32'h62, 2'b00);
    check_pred("neighbor_hold", 32'h64, 2'b01);

    // update_valid low with X payload must leave state alone
    update_pc    = 'x;
    update_taken = 1'bx;
    step();
    check_pred("x_idle", 32'h60, 2'b00);

    do_update(32'h60, 1'b1, '0);
    check_pred("back_to_weak", 32'h60, 2'b01);
    // same-cycle read/write: old value now, new value after the edge
    pred_pc      = 32'h60;
    update_valid = 1'b1;
    update_pc    = 32'h60;
    update_taken = 1'b1;
    #1;
    check("no_bypass", {30'd0, pred_state}, 32'd1);
    step();
    update_valid = 1'b0;
    check_pred("after_write", 32'h60, 2'b10);

    do_update(32'h60, 1'b1, '0);
    check_pred("trained", 32'h60, 2'b11);
    // async reset mid-cycle while an update is pending
    update_valid = 1'b1;
    update_pc    = 32'h60;
    update_taken = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_immediate", {30'd0, pred_state}, 32'd1);
    step();
    check_pred("rst_update_discarded", 32'h60, 2'b01);
    update_valid = 1'b0;
    rst          = 1'b0;
    step();
    check_pred("post_rst", 32'h60, 2'b01);
    check("post_rst_ghr", {27'd0, pred_ghr}, 32'd0);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
